// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : Shared definitions for the Hack control sequencer: state
//               encoding, instruction-register field positions, jump-condition
//               bit positions and the reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    // Value loaded into PC (and the other architectural registers) on reset
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    // Sequencer state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEMRD  = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEMWR  = 3'd4;

    // Instruction-register field positions
    localparam int IR_CI   = 15;  // 1 = C-instruction, 0 = A-instruction
    localparam int IR_A    = 12;  // ALU y operand select: 1 = M, 0 = A
    localparam int IR_C_HI = 11;  // c[5] = zx
    localparam int IR_C_LO = 6;   // c[0] = no
    localparam int IR_D1   = 5;   // destination A
    localparam int IR_D2   = 4;   // destination D
    localparam int IR_D3   = 3;   // destination M
    localparam int IR_J_HI = 2;
    localparam int IR_J_LO = 0;

    // Bit positions inside the 3-bit jump field
    localparam int JB_LT = 2;     // jump if negative
    localparam int JB_EQ = 1;     // jump if zero
    localparam int JB_GT = 0;     // jump if strictly positive

endpackage
`default_nettype wire

// File: rtl/hack_jump_eval.sv
`default_nettype none
// ============================================================================
// Module      : hack_jump_eval
// Description : Combinational jump-condition evaluator. Decides whether a
//               C-instruction jump is taken from its j field and the ALU flags.
// Ports       : j[2:0] - jump field (lt, eq, gt)
//               zr     - ALU result is zero
//               ng     - ALU result is negative
//               take   - jump is taken
// Revision    : 1.0 - initial release
// ============================================================================
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // A result is "positive" only when it is neither zero nor negative
    assign take = (j[JB_LT] & ng)
                | (j[JB_EQ] & zr)
                | (j[JB_GT] & ~(ng | zr));

endmodule
`default_nettype wire

// File: rtl/hack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hack_sequencer
// Description : Multi-cycle Hack CPU control sequencer. Fetches and decodes
//               16-bit Hack instructions, performs optional data-memory read
//               and write handshakes, drives the six ALU control bits and owns
//               the A, D and PC registers.
// Ports       : clk, rst (async, active high)
//               imem_*      - instruction fetch handshake (addr = PC)
//               dmem_*      - data memory handshake (addr = A)
//               alu_x/alu_y - ALU operands (D, and A or latched M)
//               alu_zx..no  - ALU control bits IR[11:6]
//               alu_out/zr/ng - ALU result and flags
//               pc          - current PC for debug
//               retired_cnt - retired-instruction counter (HACK_SEQ_PERF_EN)
// Config      : define HACK_SEQ_PERF_EN to add the retired_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_sequencer
    import hack_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic          alu_zx,
    output logic          alu_nx,
    output logic          alu_zy,
    output logic          alu_ny,
    output logic          alu_f,
    output logic          alu_no,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zr,
    input  logic          alu_ng,
    output logic [DW-1:0] pc
`ifdef HACK_SEQ_PERF_EN
    ,
    output logic [31:0]   retired_cnt
`endif
);

    localparam logic [DW-1:0] PC_STEP = DW'(1);
    localparam logic [DW-1:0] RST_VAL = DW'(RESET_VECTOR);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] pc_q,    pc_d;
    logic [DW-1:0] areg_q,  areg_d;
    logic [DW-1:0] dreg_q,  dreg_d;
    logic [DW-1:0] ir_q,    ir_d;
    logic [DW-1:0] m_q,     m_d;
    logic [DW-1:0] r_q,     r_d;
    logic          jmp_q,   jmp_d;   // jump decision carried from EXEC into MEMWR

    logic          w_take_now;
    logic          w_take;
    logic [DW-1:0] w_result;
    logic          w_retire_a;
    logic          w_retire_c;
    logic          w_retire;
    logic          w_unused_ir;

    hack_jump_eval u_jump_eval (
        .j    (ir_q[IR_J_HI:IR_J_LO]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (w_take_now)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        areg_d     = areg_q;
        dreg_d     = dreg_q;
        ir_d       = ir_q;
        m_d        = m_q;
        r_d        = r_q;
        jmp_d      = jmp_q;
        w_retire_a = 1'b0;
        w_retire_c = 1'b0;
        // Outside EXEC a C-instruction retires from the latched R / jump flag
        w_result   = r_q;
        w_take     = jmp_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!ir_q[IR_CI]) begin
                    w_retire_a = 1'b1;
                end else if (ir_q[IR_A]) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MEMRD: begin
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                r_d   = alu_out;
                jmp_d = w_take_now;
                if (ir_q[IR_D3]) begin
                    state_d = ST_MEMWR;
                end else begin
                    // Retiring on the EXEC edge: R is not yet visible, so use
                    // the live ALU result and jump decision directly.
                    w_retire_c = 1'b1;
                    w_result   = alu_out;
                    w_take     = w_take_now;
                end
            end
            ST_MEMWR: begin
                if (dmem_ack) begin
                    w_retire_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (w_retire_a) begin
            areg_d = ir_q;
            pc_d   = pc_q + PC_STEP;
        end

        // A is still the pre-instruction value here, so it is the jump target
        if (w_retire_c) begin
            if (ir_q[IR_D1]) begin
                areg_d = w_result;
            end
            if (ir_q[IR_D2]) begin
                dreg_d = w_result;
            end
            pc_d = w_take ? areg_q : (pc_q + PC_STEP);
        end

        if (w_retire) begin
            state_d = ST_FETCH;
        end
    end

    assign w_retire = w_retire_a | w_retire_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RST_VAL;
            areg_q  <= '0;
            dreg_q  <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            r_q     <= '0;
            jmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            areg_q  <= areg_d;
            dreg_q  <= dreg_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            r_q     <= r_d;
            jmp_q   <= jmp_d;
        end
    end

    // Requests are decoded from state; rst masks them so they drop the
    // instant reset is asserted, even though the reset state is FETCH.
    assign imem_req   = ~rst & (state_q == ST_FETCH);
    assign dmem_req   = ~rst & ((state_q == ST_MEMRD) | (state_q == ST_MEMWR));
    assign dmem_we    = ~rst & (state_q == ST_MEMWR);
    assign imem_addr  = pc_q;
    assign dmem_addr  = areg_q;
    assign dmem_wdata = r_q;
    assign pc         = pc_q;

    assign alu_x  = dreg_q;
    assign alu_y  = ir_q[IR_A] ? m_q : areg_q;
    assign alu_zx = ir_q[IR_C_HI];
    assign alu_nx = ir_q[IR_C_HI-1];
    assign alu_zy = ir_q[IR_C_HI-2];
    assign alu_ny = ir_q[IR_C_HI-3];
    assign alu_f  = ir_q[IR_C_HI-4];
    assign alu_no = ir_q[IR_C_LO];

    // IR[14:13] carry no meaning in the Hack encoding
    assign w_unused_ir = ^ir_q[14:13];

`ifdef HACK_SEQ_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (w_retire) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt_q <= 32'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_sequencer
// Description : Self-checking bench for hack_sequencer. Models the Hack ALU
//               and both memories, applies a table of instructions with
//               hand-computed register/PC/cycle expectations, then checks
//               reset taken in the middle of a data read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [15:0] alu_x, alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [15:0] pc;
`ifdef HACK_SEQ_PERF_EN
    logic [31:0] retired_cnt;
`endif

    always #5 clk = ~clk;

    hack_sequencer #(.DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_zx     (alu_zx),
        .alu_nx     (alu_nx),
        .alu_zy     (alu_zy),
        .alu_ny     (alu_ny),
        .alu_f      (alu_f),
        .alu_no     (alu_no),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .pc         (pc)
`ifdef HACK_SEQ_PERF_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    // Reference Hack ALU
    logic [15:0] m_x, m_y;
    always_comb begin
        m_x = alu_zx ? 16'h0000 : alu_x;
        m_x = alu_nx ? ~m_x : m_x;
        m_y = alu_zy ? 16'h0000 : alu_y;
        m_y = alu_ny ? ~m_y : m_y;
        alu_out = alu_f ? (m_x + m_y) : (m_x & m_y);
        alu_out = alu_no ? ~alu_out : alu_out;
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        int          iwait;
        logic [15:0] rd;
        int          dwait;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] pc;
        int          cyc;
        int          dreq;
        bit          wr;
        logic [15:0] wa;
        logic [15:0] wd;
        bit          chk_ctl;
        logic [5:0]  ctl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] instr, input int iwait, input logic [15:0] rd,
                       input int dwait, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] pcx, input int cyc, input int dreq, input bit wr,
                       input logic [15:0] wa, input logic [15:0] wd,
                       input bit chk_ctl, input logic [5:0] ctl);
        vec_t v;
        v.instr = instr; v.iwait = iwait; v.rd = rd; v.dwait = dwait;
        v.a = a; v.d = d; v.pc = pcx; v.cyc = cyc; v.dreq = dreq;
        v.wr = wr; v.wa = wa; v.wd = wd; v.chk_ctl = chk_ctl; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    // Runs one instruction, starting in FETCH at posedge+#1, until the DUT is
    // back in FETCH. Serves both memories with the requested wait counts.
    task automatic run_instr(input logic [15:0] instr, input int iwait, input logic [15:0] rd,
                             input int dwait, output int cyc, output int dreq_cyc,
                             output bit wrote, output logic [15:0] wa,
                             output logic [15:0] wd, output logic [5:0] ctl);
        int iw = 0;
        int dw = 0;
        bit fetched = 0;
        bit done = 0;
        cyc = 0; dreq_cyc = 0; wrote = 0; wa = '0; wd = '0; ctl = '0;
        while (!done && cyc < 64) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (fetched) ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
            if (imem_req && !fetched) begin
                if (iw == iwait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instr;
                    fetched    = 1;
                end else begin
                    iw++;
                end
            end
            if (dmem_req) begin
                dreq_cyc++;
                if (dw == dwait) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        wrote = 1;
                        wa    = dmem_addr;
                        wd    = dmem_wdata;
                    end else begin
                        dmem_rdata = rd;
                    end
                    dw = 0;
                end else begin
                    dw++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fetched && imem_req) done = 1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("instr_completes", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dreq;
        bit wrote;
        logic [15:0] wa, wd, exp_pc;
        logic [5:0] ctl;
        string tag;

        //  instr     iw rd       dw A        D        PC      cyc dreq wr wa       wd       cc ctl
        add(16'h1234, 0, 16'h0000, 0, 16'h1234, 16'h0000, 16'h0001, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'h0005, 0, 16'h0000, 0, 16'h0005, 16'h0000, 16'h0002, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEC10, 0, 16'h0000, 0, 16'h0005, 16'h0005, 16'h0003, 3, 0, 0, 16'h0000, 16'h0000, 1, 6'b110000);
        add(16'h0007, 0, 16'h0000, 0, 16'h0007, 16'h0005, 16'h0004, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEC10, 0, 16'h0000, 0, 16'h0007, 16'h0007, 16'h0005, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'h0010, 0, 16'h0000, 0, 16'h0010, 16'h0007, 16'h0006, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hE308, 0, 16'h0000, 2, 16'h0010, 16'h0007, 16'h0007, 6, 3, 1, 16'h0010, 16'h0007, 1, 6'b001100);
        add(16'hFC10, 0, 16'h0ABC, 0, 16'h0010, 16'h0ABC, 16'h0008, 4, 1, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hFDE8, 0, 16'h0022, 0, 16'h0023, 16'h0ABC, 16'h0009, 5, 2, 1, 16'h0010, 16'h0023, 1, 6'b110111);
        add(16'h0040, 0, 16'h0000, 0, 16'h0040, 16'h0ABC, 16'h000A, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEA90, 0, 16'h0000, 0, 16'h0040, 16'h0000, 16'h000B, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hE302, 0, 16'h0000, 0, 16'h0040, 16'h0000, 16'h0040, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEFD0, 0, 16'h0000, 0, 16'h0040, 16'h0001, 16'h0041, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hE302, 0, 16'h0000, 0, 16'h0040, 16'h0001, 16'h0042, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hE309, 0, 16'h0000, 1, 16'h0040, 16'h0001, 16'h0040, 5, 2, 1, 16'h0040, 16'h0001, 0, 6'b000000);
        add(16'hEE90, 0, 16'h0000, 0, 16'h0040, 16'hFFFF, 16'h0041, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hE304, 0, 16'h0000, 0, 16'h0040, 16'hFFFF, 16'h0040, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'h7FFF, 3, 16'h0000, 0, 16'h7FFF, 16'hFFFF, 16'h0041, 5, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEEA0, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 16'h0042, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'hEA87, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);
        add(16'h0003, 0, 16'h0000, 0, 16'h0003, 16'hFFFF, 16'h0000, 2, 0, 0, 16'h0000, 16'h0000, 0, 6'b000000);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req",   {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we",    {31'd0, dmem_we},  32'd0);
        check("rst_pc",         {16'd0, pc},         32'd0);
        check("rst_imem_addr",  {16'd0, imem_addr},  32'd0);
        check("rst_dmem_addr",  {16'd0, dmem_addr},  32'd0);
        check("rst_dmem_wdata", {16'd0, dmem_wdata}, 32'd0);
        check("rst_alu_x",      {16'd0, alu_x},      32'd0);
        rst = 1'b0;
        #1;
        check("req_after_rst", {31'd0, imem_req}, 32'd1);

        exp_pc = 16'h0000;
        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d", i);
            check({tag, "_imem_addr"}, {16'd0, imem_addr}, {16'd0, exp_pc});
            run_instr(vecs[i].instr, vecs[i].iwait, vecs[i].rd, vecs[i].dwait,
                      cyc, dreq, wrote, wa, wd, ctl);
            check({tag, "_A"},    {16'd0, dmem_addr}, {16'd0, vecs[i].a});
            check({tag, "_D"},    {16'd0, alu_x},     {16'd0, vecs[i].d});
            check({tag, "_PC"},   {16'd0, pc},        {16'd0, vecs[i].pc});
            check({tag, "_cyc"},  cyc,  vecs[i].cyc);
            check({tag, "_dreq"}, dreq, vecs[i].dreq);
            check({tag, "_wr"},   {31'd0, wrote}, {31'd0, vecs[i].wr});
            if (vecs[i].wr) begin
                check({tag, "_waddr"}, {16'd0, wa}, {16'd0, vecs[i].wa});
                check({tag, "_wdata"}, {16'd0, wd}, {16'd0, vecs[i].wd});
            end
            if (vecs[i].chk_ctl) begin
                check({tag, "_ctl"}, {26'd0, ctl}, {26'd0, vecs[i].ctl});
            end
            exp_pc = vecs[i].pc;
        end
`ifdef HACK_SEQ_PERF_EN
        check("retired_cnt", retired_cnt, 32'd21);
`endif

        // Reset taken while a data read is waiting for its ack
        imem_rdata = 16'hFC10;
        imem_ack   = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        check("memrd_req", {31'd0, dmem_req}, 32'd1);
        check("memrd_we",  {31'd0, dmem_we},  32'd0);
        @(posedge clk); #1;
        check("memrd_wait_req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_dmem_req", {31'd0, dmem_req},   32'd0);
        check("midrst_imem_req", {31'd0, imem_req},   32'd0);
        check("midrst_pc",       {16'd0, pc},         32'd0);
        check("midrst_A",        {16'd0, dmem_addr},  32'd0);
        check("midrst_D",        {16'd0, alu_x},      32'd0);
        check("midrst_alu_y",    {16'd0, alu_y},      32'd0);
        check("midrst_R",        {16'd0, dmem_wdata}, 32'd0);
`ifdef HACK_SEQ_PERF_EN
        check("midrst_retired_cnt", retired_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rerun_imem_req", {31'd0, imem_req}, 32'd1);
        run_instr(16'h0009, 0, 16'h0000, 0, cyc, dreq, wrote, wa, wd, ctl);
        check("rerun_A",   {16'd0, dmem_addr}, 32'h0009);
        check("rerun_PC",  {16'd0, pc},        32'h0001);
        check("rerun_cyc", cyc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
